// File: rtl/pa_pkg.sv
// ---------------------------------------------------------------------------
// pa_pkg : shared constants, saturation bounds and FSM state type for the
//          3x3 signed MAC processing array.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pa_pkg;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int N      = 3;
  localparam int PROD_W = 2 * DATA_W;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mac_pe.sv
// ---------------------------------------------------------------------------
// mac_pe : one signed multiply-accumulate element with saturating 32-bit
//          accumulator. o_sat flags that the update at the coming edge clamps.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mac_pe
  import pa_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic signed [DATA_W-1:0] i_a,
  input  logic signed [DATA_W-1:0] i_b,
  input  logic                     i_valid,
  input  logic                     i_clear,
  output logic signed [ACC_W-1:0]  o_acc,
  output logic                     o_sat
);

  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W:0]    sum;
  logic                     pos_ovf;
  logic                     neg_ovf;

  // Next accumulator value: one guard bit exposes overflow, which is clamped.
  always_comb begin
    prod    = i_a * i_b;
    sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
    pos_ovf = ~sum[ACC_W] &  sum[ACC_W-1];
    neg_ovf =  sum[ACC_W] & ~sum[ACC_W-1];
    acc_d   = acc_q;
    o_sat   = 1'b0;
    if (i_clear) begin
      acc_d = '0;
    end else if (i_valid) begin
      if (pos_ovf)      acc_d = ACC_MAX;
      else if (neg_ovf) acc_d = ACC_MIN;
      else              acc_d = sum[ACC_W-1:0];
      o_sat = pos_ovf | neg_ovf;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) acc_q <= '0;
    else          acc_q <= acc_d;
  end

  assign o_acc = acc_q;

endmodule

`default_nettype wire

// File: rtl/processing_array_3x3.sv
// ---------------------------------------------------------------------------
// processing_array_3x3 : 3x3 grid of signed MAC elements accumulating outer
//          products a*b^T, with IDLE/ACCUM/DONE sequencing, a read-captured
//          output matrix and a sticky saturation flag.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module processing_array_3x3
  import pa_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic [N*DATA_W-1:0]      i_a_vector,
  input  logic [N*DATA_W-1:0]      i_b_vector,
  input  logic                     i_data_valid,
  input  logic                     i_read_enable,
  input  logic                     i_clear_acc,
  output logic [N*N*ACC_W-1:0]     o_result_matrix,
  output logic                     o_computation_done,
  output logic                     o_overflow_detected
);

  logic [N*N*ACC_W-1:0] acc_flat;
  logic [N*N-1:0]       sat_vec;
  logic [N*N*ACC_W-1:0] result_q;
  state_e               state_q;
  logic                 done_q;
  logic                 ovf_q;

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      mac_pe u_pe (
        .clk     (clk),
        .i_reset (i_reset),
        .i_a     (i_a_vector[i*DATA_W +: DATA_W]),
        .i_b     (i_b_vector[j*DATA_W +: DATA_W]),
        .i_valid (i_data_valid),
        .i_clear (i_clear_acc),
        .o_acc   (acc_flat[(i*N+j)*ACC_W +: ACC_W]),
        .o_sat   (sat_vec[i*N+j])
      );
    end
  end

  // Sequencer with registered done and sticky overflow; clear wins over data.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (i_clear_acc) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (|sat_vec);
      case (state_q)
        IDLE: begin
          if (i_data_valid) state_q <= ACCUM;
        end
        ACCUM: begin
          if (!i_data_valid) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          if (i_data_valid) begin
            state_q <= ACCUM;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output matrix snapshots the pre-edge accumulators; clear does not touch it.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset)           result_q <= '0;
    else if (i_read_enable) result_q <= acc_flat;
  end

  assign o_result_matrix     = result_q;
  assign o_computation_done  = done_q;
  assign o_overflow_detected = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_processing_array_3x3.sv
// ---------------------------------------------------------------------------
// tb_processing_array_3x3 : directed self-checking bench for the 3x3 array.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_processing_array_3x3;

  logic         clk;
  logic         i_reset;
  logic [23:0]  i_a_vector;
  logic [23:0]  i_b_vector;
  logic         i_data_valid;
  logic         i_read_enable;
  logic         i_clear_acc;
  logic [287:0] o_result_matrix;
  logic         o_computation_done;
  logic         o_overflow_detected;

  int n_cmp;
  int n_err;

  processing_array_3x3 dut (
    .clk                 (clk),
    .i_reset             (i_reset),
    .i_a_vector          (i_a_vector),
    .i_b_vector          (i_b_vector),
    .i_data_valid        (i_data_valid),
    .i_read_enable       (i_read_enable),
    .i_clear_acc         (i_clear_acc),
    .o_result_matrix     (o_result_matrix),
    .o_computation_done  (o_computation_done),
    .o_overflow_detected (o_overflow_detected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack3(input int x0, input int x1, input int x2);
    logic [7:0] e0, e1, e2;
    e0 = 8'(x0);
    e1 = 8'(x1);
    e2 = 8'(x2);
    return {e2, e1, e0};
  endfunction

  function automatic logic [31:0] elem(input int idx);
    return o_result_matrix[idx*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the rising edge, leave time at edge+1.
  task automatic step(input logic v, input logic [23:0] a, input logic [23:0] b,
                      input logic rd, input logic cl);
    i_data_valid  = v;
    i_a_vector    = a;
    i_b_vector    = b;
    i_read_enable = rd;
    i_clear_acc   = cl;
    @(posedge clk);
    #1;
    i_data_valid  = 1'b0;
    i_read_enable = 1'b0;
    i_clear_acc   = 1'b0;
  endtask

  initial begin
    logic [23:0] z;
    logic [23:0] m128;
    n_cmp = 0;
    n_err = 0;
    z     = 24'd0;
    m128  = pack3(-128, -128, -128);

    // Reset and idle
    i_reset = 1'b0; i_data_valid = 1'b0; i_read_enable = 1'b0; i_clear_acc = 1'b0;
    i_a_vector = z; i_b_vector = z;
    #1;
    chk("rst_result0", elem(0), 32'd0);
    chk("rst_done",    {31'd0, o_computation_done},  32'd0);
    chk("rst_ovf",     {31'd0, o_overflow_detected}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b1;
    step(1'b0, z, z, 1'b0, 1'b0);
    step(1'b0, z, z, 1'b1, 1'b0);
    chk("idle_result8", elem(8), 32'd0);
    chk("idle_done",    {31'd0, o_computation_done}, 32'd0);

    // Identity times B
    step(1'b1, pack3(1, 0, 0), pack3(1, 2, 3), 1'b0, 1'b0);
    step(1'b1, pack3(0, 1, 0), pack3(4, 5, 6), 1'b0, 1'b0);
    step(1'b1, pack3(0, 0, 1), pack3(7, 8, 9), 1'b0, 1'b0);
    chk("id_done_busy", {31'd0, o_computation_done}, 32'd0);
    step(1'b0, z, z, 1'b1, 1'b0);
    chk("id_done", {31'd0, o_computation_done}, 32'd1);
    for (int k = 0; k < 9; k++) chk($sformatf("id_elem%0d", k), elem(k), 32'(k + 1));
    chk("id_ovf", {31'd0, o_overflow_detected}, 32'd0);

    // Signed product
    step(1'b0, z, z, 1'b0, 1'b1);
    step(1'b1, pack3(-2, 3, -128), pack3(5, -7, -128), 1'b0, 1'b0);
    step(1'b0, z, z, 1'b1, 1'b0);
    chk("sg_e00", elem(0), 32'hFFFF_FFF6);   // -10
    chk("sg_e11", elem(4), 32'hFFFF_FFEB);   // -21
    chk("sg_e22", elem(8), 32'd16384);
    chk("sg_e02", elem(2), 32'd256);
    chk("sg_e20", elem(6), 32'hFFFF_FD80);   // -640
    chk("sg_done", {31'd0, o_computation_done}, 32'd1);

    // Read during accumulate
    step(1'b0, z, z, 1'b0, 1'b1);
    step(1'b1, pack3(2, 0, 0), pack3(2, 0, 0), 1'b0, 1'b0);
    step(1'b0, z, z, 1'b0, 1'b0);
    chk("rda_done_pre", {31'd0, o_computation_done}, 32'd1);
    step(1'b1, pack3(3, 0, 0), pack3(5, 0, 0), 1'b1, 1'b0);
    chk("rda_first",   elem(0), 32'd4);
    chk("rda_done_rs", {31'd0, o_computation_done}, 32'd0);
    step(1'b0, z, z, 1'b1, 1'b0);
    chk("rda_second",  elem(0), 32'd19);

    // Clear together with read captures the pre-clear sums
    step(1'b0, z, z, 1'b1, 1'b1);
    chk("clr_rd_pre", elem(0), 32'd19);
    chk("clr_done",   {31'd0, o_computation_done}, 32'd0);

    // Clear priority over valid data
    step(1'b1, pack3(4, 0, 0), pack3(4, 0, 0), 1'b0, 1'b0);
    step(1'b1, pack3(1, 1, 1), pack3(1, 1, 1), 1'b0, 1'b1);
    chk("cp_done", {31'd0, o_computation_done},  32'd0);
    chk("cp_ovf",  {31'd0, o_overflow_detected}, 32'd0);
    step(1'b0, z, z, 1'b1, 1'b0);
    chk("cp_idle_done", {31'd0, o_computation_done}, 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("cp_elem%0d", k), elem(k), 32'd0);

    // Positive saturation: 16384 per cycle, the 131072nd cycle reaches 2^31
    for (int c = 0; c < 131071; c++) step(1'b1, m128, m128, 1'b0, 1'b0);
    chk("ov_before", {31'd0, o_overflow_detected}, 32'd0);
    step(1'b1, m128, m128, 1'b0, 1'b0);
    chk("ov_set", {31'd0, o_overflow_detected}, 32'd1);
    step(1'b1, m128, m128, 1'b0, 1'b0);
    step(1'b0, z, z, 1'b1, 1'b0);
    for (int k = 0; k < 9; k++) chk($sformatf("ov_elem%0d", k), elem(k), 32'h7FFF_FFFF);
    chk("ov_sticky", {31'd0, o_overflow_detected}, 32'd1);
    step(1'b0, z, z, 1'b0, 1'b1);
    chk("ov_cleared", {31'd0, o_overflow_detected}, 32'd0);
    chk("ov_outhold", elem(4), 32'h7FFF_FFFF);

    // Asynchronous reset mid-cycle clears the output register
    #2;
    i_reset = 1'b0;
    #1;
    chk("arst_result", elem(0), 32'd0);
    i_reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
